// File: rtl/sr_run_monitor_pkg.sv
// Shared types and constants for the sr_cpu run monitor.
// The default expected results match the Fibonacci and Factorial ROM images.
package sr_run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_HANG    = 2'd2
    } fail_code_t;

    localparam logic [31:0] FIB_RESULT  = 32'h00213d05;
    localparam logic [31:0] FACT_RESULT = 32'h1c8cfc00;
    localparam logic [4:0]  A0_REG_ADDR = 5'd10;

    function automatic logic isMatch(
        input logic [31:0] data,
        input logic [31:0] expectA,
        input logic [31:0] expectB
    );
        return (data == expectA) || (data == expectB);
    endfunction

endpackage

// File: rtl/sr_sat_counter.sv
// Up-counter that stops at MAX_VAL; synchronous clear has priority over enable.
module sr_sat_counter
    import sr_run_monitor_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sr_run_monitor.sv
// Watches an sr_cpu run through its debug port and reports PASS on a known
// result in a0, or FAIL on a timeout or a stuck fetch address.
module sr_run_monitor
    import sr_run_monitor_pkg::*;
#(
    parameter logic [4:0]  REG_ADDR    = A0_REG_ADDR,
    parameter logic [31:0] EXPECT_A    = FIB_RESULT,
    parameter logic [31:0] EXPECT_B    = FACT_RESULT,
    parameter int          TIMEOUT     = 1000,
    parameter int          STALL_LIMIT = 16,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rst_i,
    input  logic [31:0]      im_addr_i,
    input  logic [31:0]      reg_data_i,
    output logic [4:0]       reg_addr_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             done_o,
    output logic [1:0]       fail_code_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] pc_change_cnt_o,
    output logic [31:0]      match_val_o
);

    localparam int                 STALL_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX    = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [31:0]      r_prev_pc;
    logic             r_pass;
    logic             r_fail;
    logic             r_done;
    fail_code_t       r_fail_code;
    logic [31:0]      r_match_val;

    logic             w_in_run;
    logic             w_clear;
    logic             w_pc_changed;
    logic             w_stall_clear;
    logic             w_match;
    logic             w_hang;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cycle_cnt;
    logic [CNT_W-1:0] w_pc_change_cnt;
    logic [STALL_W-1:0] w_stall_cnt;

    // Counters are zeroed whenever the CPU is held in reset after arming,
    // which covers both the ARMED dwell and a restart out of RUN/PASS/FAIL.
    assign w_in_run      = (r_state == RUN);
    assign w_clear       = cpu_rst_i || (r_state == ARMED);
    assign w_pc_changed  = (im_addr_i != r_prev_pc);
    assign w_stall_clear = w_clear || (w_in_run && w_pc_changed);
    assign w_match       = isMatch(reg_data_i, EXPECT_A, EXPECT_B);
    assign w_hang        = w_in_run && !w_pc_changed && (w_stall_cnt == STALL_LAST);
    assign w_timeout     = w_in_run && (w_cycle_cnt == TIMEOUT_LAST);

    sr_sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_in_run),
        .o_count  (w_cycle_cnt)
    );

    sr_sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_pc_change_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_in_run && w_pc_changed),
        .o_count  (w_pc_change_cnt)
    );

    sr_sat_counter #(
        .WIDTH   (STALL_W),
        .MAX_VAL (STALL_MAX)
    ) u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_stall_clear),
        .i_enable (w_in_run && !w_pc_changed),
        .o_count  (w_stall_cnt)
    );

    // One decision per RUN cycle: restart, then match, then hang, then timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_prev_pc   <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_done      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_match_val <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_rst_i) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    r_prev_pc   <= im_addr_i;
                    r_pass      <= 1'b0;
                    r_fail      <= 1'b0;
                    r_done      <= 1'b0;
                    r_fail_code <= FC_NONE;
                    r_match_val <= '0;
                    if (!cpu_rst_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_prev_pc <= im_addr_i;
                    if (cpu_rst_i) begin
                        r_state <= ARMED;
                    end else if (w_match) begin
                        r_state     <= PASS;
                        r_pass      <= 1'b1;
                        r_done      <= 1'b1;
                        r_match_val <= reg_data_i;
                    end else if (w_hang) begin
                        r_state     <= FAIL;
                        r_fail      <= 1'b1;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_HANG;
                    end else if (w_timeout) begin
                        r_state     <= FAIL;
                        r_fail      <= 1'b1;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_TIMEOUT;
                    end
                end
                PASS, FAIL: begin
                    if (cpu_rst_i) begin
                        r_state     <= ARMED;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_done      <= 1'b0;
                        r_fail_code <= FC_NONE;
                        r_match_val <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign reg_addr_o      = REG_ADDR;
    assign pass_o          = r_pass;
    assign fail_o          = r_fail;
    assign done_o          = r_done;
    assign fail_code_o     = r_fail_code;
    assign cycle_cnt_o     = w_cycle_cnt;
    assign pc_change_cnt_o = w_pc_change_cnt;
    assign match_val_o     = r_match_val;

endmodule
